// File: rtl/uart_rx_fifo_wr.sv
// UART receiver feeding the write side of an async FIFO (winc/wfull handshake).
// Optional macro UART_RX_FRAME_CNT_EN adds a saturating 16-bit count of pushed frames.
module uart_rx_fifo_wr #(
  parameter int DATA_WIDTH = 8,
  parameter int OVS        = 8
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  ovr_err
`ifdef UART_RX_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int TW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pen_q, pen_d, ptyp_q, ptyp_d, perr_q, perr_d;
  logic                  sync1_q, rx_s, rxp_q;
  logic [1:0]            smp_q;
  logic                  dec, end_bit, bit_val;
  logic                  push_ok, push_ovr, stp_bad, par_bad;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge wclk) begin
    if (wrst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      rxp_q   <= 1'b1;
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      wdata_q <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      rx_s    <= sync1_q;
      rxp_q   <= rx_s;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      perr_q  <= perr_d;
      if (winc) wdata_q <= shift_q;
    end
  end

  // Mid-bit samples for the 3-point majority vote; the third sample is rx_s at the decision tick.
  always_ff @(posedge wclk) begin
    if (tcnt_q == TW'(OVS/2 - 1)) smp_q[0] <= rx_s;
    if (tcnt_q == TW'(OVS/2))     smp_q[1] <= rx_s;
  end

  assign dec     = (tcnt_q == TW'(OVS/2 + 1));
  assign end_bit = (tcnt_q == TW'(OVS - 1));
  assign bit_val = maj3(smp_q[0], smp_q[1], rx_s);

  always_comb begin
    state_d  = state_q;
    tcnt_d   = end_bit ? '0 : tcnt_q + TW'(1);
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    pen_d    = pen_q;
    ptyp_d   = ptyp_q;
    perr_d   = perr_q;
    push_ok  = 1'b0;
    push_ovr = 1'b0;
    stp_bad  = 1'b0;
    par_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        perr_d = 1'b0;
        if (rxp_q && !rx_s) begin
          state_d = START;
          pen_d   = par_en;
          ptyp_d  = par_typ;
        end
      end
      START: begin
        if (dec && bit_val) state_d = IDLE;
        else if (end_bit)   state_d = DATA;
      end
      DATA: begin
        if (dec) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        if (end_bit) begin
          if (bcnt_q == BW'(DATA_WIDTH - 1)) begin
            bcnt_d  = '0;
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (dec)     perr_d  = bit_val ^ (^shift_q) ^ ptyp_q;
        if (end_bit) state_d = STOP;
      end
      STOP: begin
        // Act at the decision tick so a following start bit is not missed.
        if (dec) begin
          if (!bit_val) begin
            stp_bad = 1'b1;
            state_d = IDLE;
          end else if (perr_q) begin
            par_bad = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        state_d  = IDLE;
        push_ok  = !wfull;
        push_ovr = wfull;
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset arriving in the PUSH or decision cycle must not leak a strobe.
  assign winc    = push_ok  & ~wrst;
  assign ovr_err = push_ovr & ~wrst;
  assign stp_err = stp_bad  & ~wrst;
  assign par_err = par_bad  & ~wrst;
  assign wdata   = winc ? shift_q : wdata_q;
  assign busy    = (state_q != IDLE);

`ifdef UART_RX_FRAME_CNT_EN
  always_ff @(posedge wclk) begin
    if (wrst)                             frame_cnt <= '0;
    else if (winc && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Directed bench for uart_rx_fifo_wr: frame table plus reset, glitch and mid-frame reset sequences.
module tb_uart_rx_fifo_wr;
  localparam int OVS = 8;
  localparam int DW  = 8;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          wfull = 1'b0;
  logic          winc, busy, par_err, stp_err, ovr_err;
  logic [DW-1:0] wdata;
`ifdef UART_RX_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  uart_rx_fifo_wr #(.DATA_WIDTH(DW), .OVS(OVS)) dut (
    .wclk(wclk), .wrst(wrst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .par_err(par_err),
    .stp_err(stp_err), .ovr_err(ovr_err)
`ifdef UART_RX_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int            cyc = 0, n_winc = 0, n_par = 0, n_stp = 0, n_ovr = 0, n_viol = 0, winc_cyc = 0;
  logic [DW-1:0] last_wd = '0;
  int            checks = 0, errors = 0;

  always @(posedge wclk) begin
    #1;
    cyc <= cyc + 1;
    if (winc) begin
      n_winc   <= n_winc + 1;
      last_wd  <= wdata;
      winc_cyc <= cyc + 1;
      if (wfull) n_viol <= n_viol + 1;
    end
    if (par_err) n_par <= n_par + 1;
    if (stp_err) n_stp <= n_stp + 1;
    if (ovr_err) n_ovr <= n_ovr + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pb,
                            input logic sb, output int c0);
    @(negedge wclk);
    rx_in = 1'b0;
    c0 = cyc;
    repeat (OVS) @(negedge wclk);
    for (int i = 0; i < DW; i++) begin
      rx_in = d[i];
      repeat (OVS) @(negedge wclk);
    end
    if (pe) begin
      rx_in = pb;
      repeat (OVS) @(negedge wclk);
    end
    rx_in = sb;
    repeat (OVS) @(negedge wclk);
    rx_in = 1'b1;
    repeat (2*OVS) @(negedge wclk);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic pe, pt, pb, sb, full;
    logic ew, ep, es, eo;
  } vec_t;

  vec_t tv [9];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, bw, bp, bs, bo, bv;
    //          d      pe    pt    pb    sb    full  ew    ep    es    eo
    tv[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[4] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[6] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held 3 cycles with the line low.
    @(negedge wclk);
    wrst = 1'b1;
    rx_in = 1'b0;
    repeat (3) @(negedge wclk);
    chk("rst winc", winc, 0);
    chk("rst busy", busy, 0);
    chk("rst wdata", wdata, 0);
    chk("rst par_err", par_err, 0);
    chk("rst stp_err", stp_err, 0);
    chk("rst ovr_err", ovr_err, 0);
    wrst = 1'b0;
    rx_in = 1'b1;
    bw = n_winc; bs = n_stp;
    repeat (20) @(negedge wclk);
    chk("post-rst winc", n_winc - bw, 0);
    chk("post-rst stp", n_stp - bs, 0);
    chk("post-rst busy", busy, 0);

    for (int k = 0; k < 9; k++) begin
      par_en = tv[k].pe;
      par_typ = tv[k].pt;
      wfull = tv[k].full;
      bw = n_winc; bp = n_par; bs = n_stp; bo = n_ovr; bv = n_viol;
      send_frame(tv[k].d, tv[k].pe, tv[k].pb, tv[k].sb, c0);
      wfull = 1'b0;
      chk($sformatf("v%0d winc", k), n_winc - bw, int'(tv[k].ew));
      if (tv[k].ew) begin
        chk($sformatf("v%0d wdata", k), last_wd, tv[k].d);
        chk($sformatf("v%0d latency", k), winc_cyc - c0, 81 + OVS * int'(tv[k].pe));
      end
      chk($sformatf("v%0d par_err", k), n_par - bp, int'(tv[k].ep));
      chk($sformatf("v%0d stp_err", k), n_stp - bs, int'(tv[k].es));
      chk($sformatf("v%0d ovr_err", k), n_ovr - bo, int'(tv[k].eo));
      chk($sformatf("v%0d winc-while-full", k), n_viol - bv, 0);
      chk($sformatf("v%0d busy", k), busy, 0);
      chk($sformatf("v%0d wdata hold", k), wdata, last_wd);
    end
    par_en = 1'b0;
    par_typ = 1'b0;

    // 3-cycle low glitch.
    bw = n_winc; bp = n_par; bs = n_stp; bo = n_ovr;
    @(negedge wclk);
    rx_in = 1'b0;
    repeat (3) @(negedge wclk);
    rx_in = 1'b1;
    repeat (3) @(negedge wclk);
    chk("glitch busy mid", busy, 1);
    repeat (20) @(negedge wclk);
    chk("glitch winc", n_winc - bw, 0);
    chk("glitch errs", (n_par - bp) + (n_stp - bs) + (n_ovr - bo), 0);
    chk("glitch busy", busy, 0);

    // Reset in the middle of the data bits of 0x81.
    @(negedge wclk);
    rx_in = 1'b0;
    repeat (OVS) @(negedge wclk);
    rx_in = 1'b1;
    repeat (OVS) @(negedge wclk);
    rx_in = 1'b0;
    repeat (2*OVS) @(negedge wclk);
    chk("midrst busy before", busy, 1);
    wrst = 1'b1;
    rx_in = 1'b1;
    repeat (2) @(negedge wclk);
    wrst = 1'b0;
    repeat (20) @(negedge wclk);
    chk("midrst winc", n_winc - bw, 0);
    chk("midrst errs", (n_par - bp) + (n_stp - bs) + (n_ovr - bo), 0);
    chk("midrst busy", busy, 0);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, c0);
    chk("after-rst winc", n_winc - bw, 1);
    chk("after-rst wdata", last_wd, 8'h42);
    chk("after-rst latency", winc_cyc - c0, 81);
`ifdef UART_RX_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
